// File: rtl/mdu_hilo_if.sv
// Request/result bundle between the EX stage and the HI/LO multiply-divide unit.
interface mdu_hilo_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             HiWe;
  logic             LoWe;
  logic [WIDTH-1:0] Wdata;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (
    output Start, Op, A, B, HiWe, LoWe, Wdata,
    input  Busy, Done, Hi, Lo
  );

  modport slave (
    input  Start, Op, A, B, HiWe, LoWe, Wdata,
    output Busy, Done, Hi, Lo
  );
endinterface

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// One operand bit per cycle: shift-add multiply, restoring divide on magnitudes,
// followed by a single sign-fix cycle that commits the result to HI/LO.
module mdu_hilo #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input logic        CLK,
  input logic        RST,
  mdu_hilo_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               is_div_q, is_div_d;
  logic               sign_a_q, sign_a_d;     // dividend sign, drives remainder sign
  logic               neg_res_q, neg_res_d;   // operand signs differ on a signed op
  logic               div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;     // product upper half / partial remainder
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;     // multiplier / dividend-then-quotient
  logic [WIDTH-1:0]   opnd_q, opnd_d;         // multiplicand / divisor magnitude
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  // Combinational temporaries
  logic               signed_op, sa, sb;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_trial;
  logic [2*WIDTH-1:0] prod_fix;

  // State register and datapath flops; reset discards any operation in flight
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      is_div_q   <= 1'b0;
      sign_a_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      div_zero_q <= 1'b0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      opnd_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      is_div_q   <= is_div_d;
      sign_a_q   <= sign_a_d;
      neg_res_q  <= neg_res_d;
      div_zero_q <= div_zero_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      opnd_q     <= opnd_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic: accept/MT* writes in IDLE, one iteration per CALC cycle, commit in FIX
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    is_div_d   = is_div_q;
    sign_a_d   = sign_a_q;
    neg_res_d  = neg_res_q;
    div_zero_d = div_zero_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    opnd_d     = opnd_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;

    // Op[0]=0 selects the signed variants (MULT/DIV)
    signed_op  = ~bus.Op[0];
    sa         = signed_op & bus.A[WIDTH-1];
    sb         = signed_op & bus.B[WIDTH-1];
    abs_a      = sa ? -bus.A : bus.A;
    abs_b      = sb ? -bus.B : bus.B;

    mul_sum    = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    // Two spare bits: shifted remainder can exceed WIDTH bits, MSB is the borrow
    div_trial  = {1'b0, acc_hi_q, acc_lo_q[WIDTH-1]} - {2'b00, opnd_q};

    prod_fix   = neg_res_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};

    case (state_q)
      S_IDLE: begin
        // MT* writes land even when a Start is accepted; FIX overwrites them later
        if (bus.HiWe) hi_d = bus.Wdata;
        if (bus.LoWe) lo_d = bus.Wdata;
        if (bus.Start) begin
          is_div_d   = bus.Op[1];
          sign_a_d   = sa;
          neg_res_d  = sa ^ sb;
          div_zero_d = bus.Op[1] && (bus.B == '0);
          count_d    = '0;
          acc_hi_d   = '0;
          acc_lo_d   = bus.Op[1] ? abs_a : abs_b;
          opnd_d     = bus.Op[1] ? abs_b : abs_a;
          state_d    = S_CALC;
        end
      end
      S_CALC: begin
        if (is_div_q) begin
          if (!div_trial[WIDTH+1]) begin
            acc_hi_d = div_trial[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi_d = {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[WIDTH-1:1]};
        end
        count_d = count_q + 1'b1;
        if (count_q == '1) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          // Divide by zero: raw iteration already leaves all-ones quotient and |A|
          // remainder; the dividend-sign fix on the remainder restores raw A
          lo_d = (neg_res_q && !div_zero_q) ? -acc_lo_q : acc_lo_q;
          hi_d = sign_a_q ? -acc_hi_q : acc_hi_q;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.Busy = (state_q != S_IDLE);
  assign bus.Done = done_q;
  assign bus.Hi   = hi_q;
  assign bus.Lo   = lo_q;

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multi-cycle multiply/divide responder for the MIPS datapath.
- Owns the HI/LO architectural registers.
- The EX stage issues MULT/MULTU/DIV/DIVU requests through a start/busy/done handshake. EX and WB read results via Hi/Lo for MFHI/MFLO. MTHI/MTLO write them directly.
- Iterative engine: shift-add multiply, restoring divide, one operand bit per cycle.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 5, iteration counter width; must satisfy 2**CNT_W == WIDTH.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RST  input  1  asynchronous, active-high reset.
- Start  input  1  request strobe; sampled only in IDLE.
- Op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- A  input  WIDTH  rs operand (multiplicand or dividend).
- B  input  WIDTH  rt operand (multiplier or divisor).
- HiWe  input  1  MTHI write enable.
- LoWe  input  1  MTLO write enable.
- Wdata  input  WIDTH  MTHI/MTLO data.
- Busy  output  1  high while an operation is in flight.
- Done  output  1  one-cycle pulse when Hi/Lo hold a new result.
- Hi  output  WIDTH  HI register (product[63:32] or remainder).
- Lo  output  WIDTH  LO register (product[31:0] or quotient).

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE; Hi=0, Lo=0, Busy=0, Done=0.
  - Counter and working registers cleared.
  - The in-flight operation is discarded.
- States are IDLE, CALC and FIX.
- IDLE:
  - Start=1 at an edge latches Op, A and B, and records sign bits for signed ops.
  - Working operands are loaded as absolute values for MULT/DIV and raw values for MULTU/DIVU.
  - count=0; transition to CALC.
  - Busy=1 from the next cycle.
- CALC:
  - One iteration per edge, 32 edges total (count 0..31).
  - On count==31, transition to FIX.
  - Multiply: if multiplier LSB is set, add multiplicand to the 64-bit accumulator upper half; then shift right one bit.
  - Divide (restoring): shift {rem,quot} left one bit; trial-subtract divisor from rem; if no borrow, keep the difference and set quot LSB.
- FIX (one edge):
  - Apply sign correction and write Hi/Lo.
  - Done<=1 for exactly one cycle; Busy<=0; state=IDLE.
- Latency: Start sampled at edge 0 -> Hi/Lo updated and Done=1 after edge 33. Busy is high in the cycles after edges 0..32.
- Sign rules:
  - MULT: negate the 64-bit product if sign(A)!=sign(B).
  - DIV: quotient truncates toward zero and is negated if signs differ; remainder takes the sign of the dividend.
  - All arithmetic is modulo 2^WIDTH per half.
  - DIV 0x80000000/0xFFFFFFFF gives Lo=0x80000000, Hi=0.
- Divide by zero (B==0, DIV or DIVU): Lo=all ones, Hi=A (raw), no sign fix. Latency is unchanged.
- Handshake and concurrency:
  - Start while Busy is ignored; no queueing.
  - Start in the Done cycle is accepted, since state is IDLE.
  - A/B/Op are only sampled at acceptance; changes during CALC have no effect.
- MTHI/MTLO:
  - HiWe/LoWe in IDLE write Wdata into Hi/Lo at the edge, independently of each other.
  - HiWe/LoWe while Busy (CALC/FIX) are ignored; the pipeline stalls MT* behind Busy.
  - HiWe/LoWe together with an accepted Start: the write takes effect, and the result overwrites it at FIX.
- Hi/Lo are stable outside the FIX edge and MT* writes. Readers may sample them any cycle; values are architecturally valid only when Busy=0.
- Done never asserts without a preceding accepted Start.

Test Plan:
- Reset then idle -> Hi=0, Lo=0, Busy=0, Done=0. RST pulse mid-CALC (cycle 10) -> all outputs 0 immediately, no Done.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Done one cycle after edge 33, Hi=0xFFFFFFFE, Lo=0x00000001, Busy high 33 cycles. MULT A=-3 (0xFFFFFFFD), B=7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
- DIV A=-7 (0xFFFFFFF9), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU A=7, B=2 -> Lo=3, Hi=1. DIV A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- DIVU A=0x00001234, B=0 -> Lo=0xFFFFFFFF, Hi=0x00001234. DIV A=-5, B=0 -> Lo=0xFFFFFFFF, Hi=0xFFFFFFFB.
- MULTU 6*7 in flight:
  - Start pulse with A=1, B=1 at cycle 5 -> ignored; result Lo=42, Hi=0.
  - HiWe=1, Wdata=0xDEAD at cycle 8 -> ignored.
- Idle HiWe, Wdata=0xCAFE -> Hi=0xCAFE next cycle, Lo unchanged. LoWe then written -> Lo updated.
- Back-to-back: Start asserted in the Done cycle -> accepted, second Done 34 cycles after the first.
